irq_ctl: RTL and testbench

//  Interrupt front end for the 65C02 microcoded core, directly upstream of the microcode sequencer.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/sync_chain.sv | 22 ++
 rtl/irq_ctl.sv | 113 +++++++++++
 tb/tb_irq_ctl.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 65C02 microcoded core: interrupt vector low
// bytes (page FF implied) and the WAI/STP hold state type.
package cpu_pkg;

  localparam logic [7:0] VEC_NMI = 8'hFA;
  localparam logic [7:0] VEC_RES = 8'hFC;
  localparam logic [7:0] VEC_IRQ = 8'hFE;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    WAIT = 2'd1,
    STOP = 2'd2
  } irq_state_t;

endpackage

// File: rtl/sync_chain.sv
// Multi-flop pin synchronizer. Resets to 1 so the active-low pins it
// carries read as deasserted while the core is held in reset.
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  // Shift the raw pin through STAGES flops; the oldest sample is the output.
  always_ff @(posedge clk) begin
    if (reset) ff <= '1;
    else       ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/irq_ctl.sv
// Interrupt front end for the 65C02 microcoded core. Synchronizes irq_n and
// nmi_n, edge-detects NMI, raises the sequencer interrupt request, provides
// the effective I mask and latches the vector low byte on acceptance.
// Optional WAI/STP hold logic is built when IRQ_CTL_WAI_STOP_EN is defined.
module irq_ctl
  import cpu_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       irq_n,
  input  logic       nmi_n,
  input  logic       sync,
  input  logic       i_flag,
  input  logic       wai_req,
  input  logic       stp_req,
  output logic       int_req,
  output logic       i_mask,
  output logic [7:0] vec_lo,
  output logic       taken,
  output logic       rdy_hold
);

  logic irq_s;
  logic nmi_s;
  logic nmi_prev;
  logic nmi_pend;
  logic nmi_edge;
  logic irq_lvl;

  sync_chain #(.STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .reset (reset),
    .d     (irq_n),
    .q     (irq_s)
  );

  sync_chain #(.STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nmi_n),
    .q     (nmi_s)
  );

  assign irq_lvl  = ~irq_s;
  assign nmi_edge = nmi_prev & ~nmi_s;
  assign i_mask   = i_flag & ~nmi_pend;
  assign taken    = sync & int_req & ~i_mask & ~rdy_hold;

  // Previous synchronized NMI level, reset high so reset release is no edge.
  always_ff @(posedge clk) begin
    if (reset) nmi_prev <= 1'b1;
    else       nmi_prev <= nmi_s;
  end

  // NMI pending flag: a fresh falling edge beats the clear from acceptance.
  always_ff @(posedge clk) begin
    if (reset)                    nmi_pend <= 1'b0;
    else if (nmi_edge)            nmi_pend <= 1'b1;
    else if (taken && nmi_pend)   nmi_pend <= 1'b0;
  end

  // Registered request to the sequencer; IRQ is a level, never latched.
  always_ff @(posedge clk) begin
    if (reset) int_req <= 1'b0;
    else       int_req <= nmi_pend | irq_lvl;
  end

  // Vector low byte, updated only on acceptance; NMI outranks IRQ.
  always_ff @(posedge clk) begin
    if (reset)      vec_lo <= VEC_RES;
    else if (taken) vec_lo <= nmi_pend ? VEC_NMI : VEC_IRQ;
  end

`ifdef IRQ_CTL_WAI_STOP_EN
  irq_state_t state;
  irq_state_t state_nxt;

  // Next-state logic: WAIT wakes on any request even when masked; STOP only leaves on reset.
  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (stp_req)      state_nxt = STOP;
        else if (wai_req) state_nxt = WAIT;
      end
      WAIT: begin
        if (nmi_pend | irq_lvl) state_nxt = RUN;
      end
      STOP:    state_nxt = STOP;
      default: state_nxt = RUN;
    endcase
  end

  // State and the registered core stall derived from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      rdy_hold <= 1'b0;
    end else begin
      state    <= state_nxt;
      rdy_hold <= (state_nxt != RUN);
    end
  end
`else
  logic unused_req;

  assign unused_req = wai_req ^ stp_req;
  assign rdy_hold   = 1'b0;
`endif

endmodule

// File: tb/tb_irq_ctl.sv
// Self-checking bench for irq_ctl: directed scenarios followed by random
// stimulus, all checked against a behavioural model kept in the bench.
module tb_irq_ctl;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       irq_n = 1'b1;
  logic       nmi_n = 1'b1;
  logic       sync = 1'b0;
  logic       i_flag = 1'b1;
  logic       wai_req = 1'b0;
  logic       stp_req = 1'b0;
  logic       int_req;
  logic       i_mask;
  logic [7:0] vec_lo;
  logic       taken;
  logic       rdy_hold;

  int n_checked = 0;
  int n_failed  = 0;

  // Reference model state
  bit         irq_hist[$];
  bit         nmi_hist[$];
  bit         m_prev;
  bit         m_pend;
  bit         m_int;
  bit         m_rdy;
  bit         m_valid = 1'b0;
  int         m_state = 0;
  logic [7:0] m_vec;
  bit         saw_taken;

  always #5 clk = ~clk;

  irq_ctl #(.SYNC_STAGES(S)) dut (
    .clk      (clk),
    .reset    (reset),
    .irq_n    (irq_n),
    .nmi_n    (nmi_n),
    .sync     (sync),
    .i_flag   (i_flag),
    .wai_req  (wai_req),
    .stp_req  (stp_req),
    .int_req  (int_req),
    .i_mask   (i_mask),
    .vec_lo   (vec_lo),
    .taken    (taken),
    .rdy_hold (rdy_hold)
  );

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checked++;
    if (obs !== exp) begin
      n_failed++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model view of the sequencer-facing outputs for the current inputs
  function automatic bit mMask();
    return i_flag && !m_pend;
  endfunction

  function automatic bit mTaken();
    return sync && m_int && !mMask() && !m_rdy;
  endfunction

  // Advance the model across one rising edge using the inputs held at it
  task automatic modelEdge();
    bit tk;
    bit nmi_lvl_s;
    bit irq_active;
    bit nmi_fall;
    if (reset) begin
      irq_hist.delete();
      nmi_hist.delete();
      for (int i = 0; i < S; i++) begin
        irq_hist.push_back(1'b1);
        nmi_hist.push_back(1'b1);
      end
      m_prev  = 1'b1;
      m_pend  = 1'b0;
      m_int   = 1'b0;
      m_vec   = 8'hFC;
      m_state = 0;
      m_rdy   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      tk         = mTaken();
      nmi_lvl_s  = nmi_hist[S-1];
      irq_active = !irq_hist[S-1];
      nmi_fall   = m_prev && !nmi_lvl_s;
`ifdef IRQ_CTL_WAI_STOP_EN
      if (m_state == 0) begin
        if (stp_req)      m_state = 2;
        else if (wai_req) m_state = 1;
      end else if (m_state == 1) begin
        if (m_pend || irq_active) m_state = 0;
      end
      m_rdy = (m_state != 0);
`endif
      m_int = m_pend || irq_active;
      if (tk) m_vec = m_pend ? 8'hFA : 8'hFE;
      if (nmi_fall)          m_pend = 1'b1;
      else if (tk && m_pend) m_pend = 1'b0;
      m_prev = nmi_lvl_s;
      irq_hist.push_front(irq_n);
      void'(irq_hist.pop_back());
      nmi_hist.push_front(nmi_n);
      void'(nmi_hist.pop_back());
    end
  endtask

  // Drive one cycle of inputs, compare every output, then cross the edge
  task automatic applyStimulus(input bit r, input bit in, input bit nn, input bit sy,
                               input bit ifl, input bit wr, input bit sr);
    @(negedge clk);
    reset   = r;
    irq_n   = in;
    nmi_n   = nn;
    sync    = sy;
    i_flag  = ifl;
    wai_req = wr;
    stp_req = sr;
    #1;
    saw_taken = taken;
    if (m_valid) begin
      checkOutput("int_req",  8'(int_req),  8'(m_int));
      checkOutput("i_mask",   8'(i_mask),   8'(mMask()));
      checkOutput("taken",    8'(taken),    8'(mTaken()));
      checkOutput("vec_lo",   vec_lo,       m_vec);
      checkOutput("rdy_hold", 8'(rdy_hold), 8'(m_rdy));
    end
    @(posedge clk);
    modelEdge();
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int cnt;
    bit r_in, r_nn, r_ifl;

    // Reset held with irq_n low: no request, reset vector
    repeat (3) begin
      applyStimulus(1, 0, 1, 0, 1, 0, 0);
      #1;
      checkOutput("rst_int_req", 8'(int_req), 8'h00);
      checkOutput("rst_vec",     vec_lo,      8'hFC);
    end
    for (int k = 1; k <= S + 1; k++) begin
      applyStimulus(0, 0, 1, 0, 1, 0, 0);
      #1;
      checkOutput("irq_latency", 8'(int_req), 8'((k == S + 1) ? 1 : 0));
    end

    // IRQ masked by I flag, then accepted once I drops
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      applyStimulus(0, 0, 1, k[0], 1, 0, 0);
      if (saw_taken) cnt++;
    end
    checkOutput("irq_masked", 8'(cnt), 8'h00);
    applyStimulus(0, 0, 1, 1, 0, 0, 0);
    checkOutput("irq_taken", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("irq_vec", vec_lo, 8'hFE);
    repeat (S + 3) applyStimulus(0, 1, 1, 0, 1, 0, 0);

    // NMI overrides I flag, accepted once, not retriggered while held low
    repeat (S + 2) applyStimulus(0, 1, 0, 0, 1, 0, 0);
    #1;
    checkOutput("nmi_unmask", 8'(i_mask), 8'h00);
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    checkOutput("nmi_taken", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("nmi_vec",   vec_lo,      8'hFA);
    checkOutput("nmi_clear", 8'(i_mask),  8'h01);
    cnt = 0;
    repeat (20) begin
      applyStimulus(0, 1, 0, 1, 1, 0, 0);
      if (saw_taken) cnt++;
    end
    checkOutput("nmi_single", 8'(cnt), 8'h00);

    // NMI and IRQ together: NMI first, then IRQ
    repeat (S + 2) applyStimulus(0, 1, 1, 0, 0, 0, 0);
    repeat (S + 2) applyStimulus(0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("prio_taken1", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("prio_vec1", vec_lo, 8'hFA);
    applyStimulus(0, 0, 0, 1, 0, 0, 0);
    checkOutput("prio_taken2", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("prio_vec2", vec_lo, 8'hFE);

    // New NMI edge coincident with acceptance of the previous NMI
    repeat (S + 1) applyStimulus(0, 1, 1, 0, 1, 0, 0);
    repeat (S + 2) applyStimulus(0, 1, 0, 0, 1, 0, 0);
    repeat (S + 1) applyStimulus(0, 1, 1, 0, 1, 0, 0);
    repeat (S)     applyStimulus(0, 1, 0, 0, 1, 0, 0);
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    checkOutput("coinc_taken1", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("coinc_vec1",   vec_lo,       8'hFA);
    checkOutput("coinc_pend",   8'(i_mask),   8'h00);
    applyStimulus(0, 1, 0, 1, 1, 0, 0);
    checkOutput("coinc_taken2", 8'(saw_taken), 8'h01);
    #1;
    checkOutput("coinc_vec2",   vec_lo,       8'hFA);

`ifdef IRQ_CTL_WAI_STOP_EN
    // WAI with I set: wake on IRQ without taking it; STP held until reset
    repeat (S + 2) applyStimulus(0, 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 1, 0);
    #1;
    checkOutput("wai_hold", 8'(rdy_hold), 8'h01);
    cnt = 0;
    for (int k = 0; k < 10 && rdy_hold; k++) begin
      applyStimulus(0, 0, 1, 1, 1, 0, 0);
      if (saw_taken) cnt++;
      #1;
    end
    checkOutput("wai_wake",     8'(rdy_hold), 8'h00);
    checkOutput("wai_no_taken", 8'(cnt),      8'h00);
    repeat (S + 2) applyStimulus(0, 1, 1, 0, 1, 0, 0);
    applyStimulus(0, 1, 1, 0, 1, 0, 1);
    cnt = 0;
    repeat (10) begin
      applyStimulus(0, 0, 0, 1, 0, 0, 0);
      if (saw_taken) cnt++;
    end
    #1;
    checkOutput("stp_hold",     8'(rdy_hold), 8'h01);
    checkOutput("stp_no_taken", 8'(cnt),      8'h00);
    applyStimulus(1, 1, 1, 0, 1, 0, 0);
    #1;
    checkOutput("stp_reset", 8'(rdy_hold), 8'h00);
`endif

    // Random traffic against the model
    r_in  = 1'b1;
    r_nn  = 1'b1;
    r_ifl = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 7) == 0) r_in  = ~r_in;
      if ($urandom_range(0, 5) == 0) r_nn  = ~r_nn;
      if ($urandom_range(0, 9) == 0) r_ifl = ~r_ifl;
      applyStimulus(($urandom_range(0, 199) == 0), r_in, r_nn,
                    ($urandom_range(0, 2) == 0), r_ifl,
                    ($urandom_range(0, 39) == 0), ($urandom_range(0, 149) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checked, n_failed);
    $finish;
  end

endmodule
